// File: rtl/ssi_encoder_emulator.sv
// SSI absolute-encoder slave: latches position on the master's first falling clock,
// shifts it out MSB first on rising clocks, then holds data low for the monoflop time.
module ssi_encoder_emulator #(
  parameter int POSITION_WIDTH  = 25,
  parameter int MONOFLOP_CYCLES = 2000,
  parameter bit GRAY_CODE_EN    = 1'b1
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  logic                      emulator_enable_in,
  input  logic [POSITION_WIDTH-1:0] position_in,
  input  logic                      ssi_clk_in,
  output logic                      ssi_data_out,
  output logic                      busy_out,
  output logic                      frame_done_out,
  output logic                      frame_error_out
);

  localparam int MCW = $clog2(MONOFLOP_CYCLES + 1);
  localparam int BCW = $clog2(POSITION_WIDTH + 1);
  localparam logic [MCW-1:0] MONO_MAX = MCW'(MONOFLOP_CYCLES);
  localparam logic [BCW-1:0] BIT_MAX  = BCW'(POSITION_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, MONO} state_t;

  state_t                    r_state;
  logic                      r_s1, r_s2, r_s3;
  logic [POSITION_WIDTH-1:0] r_shreg;
  logic [BCW-1:0]            r_bit_cnt;
  logic [MCW-1:0]            r_mono_cnt;
  logic                      r_data, r_done, r_err;

  logic                      w_rise, w_fall, w_timeout;
  logic [POSITION_WIDTH-1:0] w_frame;

  // Edges are taken from s2/s3 so outputs move on the edge that loads s3.
  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  assign w_timeout = (r_mono_cnt == MONO_MAX);
  assign w_frame   = GRAY_CODE_EN ? (position_in ^ (position_in >> 1)) : position_in;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1       <= 1'b1;
      r_s2       <= 1'b1;
      r_s3       <= 1'b1;
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_mono_cnt <= '0;
      r_data     <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_s1   <= ssi_clk_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (!emulator_enable_in) begin
        // Disabling mid-transfer is an abort; disabling during monoflop is not.
        r_state    <= IDLE;
        r_data     <= 1'b1;
        r_bit_cnt  <= '0;
        r_mono_cnt <= '0;
        r_err      <= (r_state == SHIFT);
      end else begin
        if (w_rise || w_fall)
          r_mono_cnt <= '0;
        else if (!w_timeout)
          r_mono_cnt <= r_mono_cnt + 1'b1;

        case (r_state)
          IDLE: begin
            r_data    <= 1'b1;
            r_bit_cnt <= '0;
            if (w_fall) begin
              r_shreg <= w_frame;
              r_state <= SHIFT;
            end
          end
          SHIFT: begin
            // A rise clears the counter, so it outranks a same-cycle timeout.
            if (w_rise) begin
              if (r_bit_cnt < BIT_MAX) begin
                r_data    <= r_shreg[POSITION_WIDTH-1];
                r_shreg   <= r_shreg << 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end else begin
                r_data  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= MONO;
              end
            end else if (w_timeout) begin
              r_err     <= 1'b1;
              r_data    <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= IDLE;
            end
          end
          MONO: begin
            if (!w_rise && !w_fall && w_timeout && r_s3) begin
              r_data    <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign ssi_data_out    = r_data;
  assign busy_out        = (r_state != IDLE);
  assign frame_done_out  = r_done;
  assign frame_error_out = r_err;

endmodule

// File: tb/tb_ssi_encoder_emulator.sv
// Bench for ssi_encoder_emulator: a Gray and a binary instance share one SSI master;
// each received bit is compared with the frame computed from the position value.
module tb_ssi_encoder_emulator;
  localparam int PW = 25;
  localparam int M  = 2000;
  localparam int H  = 10;     // SSI half period in sys_clk cycles
  localparam int LAT_TO = M + 4; // posedges from a last clock edge to timeout output

  logic          sys_clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [PW-1:0] pos;
  logic          ssi;
  logic          data_g, busy_g, done_g, err_g;
  logic          data_b, busy_b, done_b, err_b;

  int n_cmp = 0, n_fail = 0;
  int dcnt_g = 0, dcnt_b = 0, ecnt_g = 0, ecnt_b = 0, both_cnt = 0;
  int exp_done = 0, exp_err = 0;

  always #5 sys_clk = ~sys_clk;

  ssi_encoder_emulator #(.POSITION_WIDTH(PW), .MONOFLOP_CYCLES(M), .GRAY_CODE_EN(1'b1)) dut_g (
    .sys_clk(sys_clk), .reset_n(reset_n), .emulator_enable_in(en), .position_in(pos),
    .ssi_clk_in(ssi), .ssi_data_out(data_g), .busy_out(busy_g),
    .frame_done_out(done_g), .frame_error_out(err_g));

  ssi_encoder_emulator #(.POSITION_WIDTH(PW), .MONOFLOP_CYCLES(M), .GRAY_CODE_EN(1'b0)) dut_b (
    .sys_clk(sys_clk), .reset_n(reset_n), .emulator_enable_in(en), .position_in(pos),
    .ssi_clk_in(ssi), .ssi_data_out(data_b), .busy_out(busy_b),
    .frame_done_out(done_b), .frame_error_out(err_b));

  always @(negedge sys_clk) begin
    if (done_g) dcnt_g++;
    if (done_b) dcnt_b++;
    if (err_g)  ecnt_g++;
    if (err_b)  ecnt_b++;
    if ((done_g && err_g) || (done_b && err_b)) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit i of a frame as the reader sees it: frame bits MSB first, then a trailing 0.
  function automatic logic exp_bit(input logic [PW-1:0] p, input bit gray, input int i);
    logic [PW-1:0] f;
    f = gray ? (p ^ (p >> 1)) : p;
    return (i < PW) ? f[PW-1-i] : 1'b0;
  endfunction

  // Ends at the negedge 3 posedges after the last rising SSI edge was driven.
  task automatic do_frame(input logic [PW-1:0] p, input int nrises);
    pos = p;
    for (int i = 0; i < nrises; i++) begin
      @(posedge sys_clk); #1 ssi = 1'b0;
      repeat (H) @(posedge sys_clk);
      if (i == 0) pos = PW'($urandom);
      #1 ssi = 1'b1;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      chk($sformatf("bit%0d_gray", i), {31'b0, data_g}, {31'b0, exp_bit(p, 1'b1, i)});
      chk($sformatf("bit%0d_bin", i),  {31'b0, data_b}, {31'b0, exp_bit(p, 1'b0, i)});
      if (i == PW) begin
        chk("done_pulse_g", {31'b0, done_g}, 32'd1);
        chk("done_pulse_b", {31'b0, done_b}, 32'd1);
      end
      if (i != nrises - 1) repeat (H - 4) @(posedge sys_clk);
    end
  endtask

  // Counts posedges (starting from 3) until idle data (what=0) or an error pulse (what=1).
  task automatic wait_evt(input int what, output int n);
    n = 3;
    forever begin
      @(posedge sys_clk); n++;
      @(negedge sys_clk);
      if (what == 0 && data_g === 1'b1 && data_b === 1'b1) break;
      if (what == 1 && err_g === 1'b1) break;
      if (n > 3 * M) break;
    end
  endtask

  initial begin
    int n;
    logic [PW-1:0] rp;
    reset_n = 1'b0; en = 1'b1; pos = '0; ssi = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_data", {30'b0, data_g, data_b}, 32'd3);
    chk("rst_busy", {30'b0, busy_g, busy_b}, 32'd0);
    chk("rst_pulses", {28'b0, done_g, done_b, err_g, err_b}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge sys_clk);

    // Full frame, small position, then monoflop release
    do_frame(25'h0000005, PW + 1); exp_done++;
    wait_evt(0, n);
    chk("mono_release_cycles", n, LAT_TO);
    chk("idle_busy", {30'b0, busy_g, busy_b}, 32'd0);

    // Alternating pattern
    do_frame(25'h1555555, PW + 1); exp_done++;
    wait_evt(0, n);
    chk("mono_release_cycles2", n, LAT_TO);

    // Master stalls after 10 rises
    do_frame(PW'($urandom), 10); exp_err++;
    wait_evt(1, n);
    chk("stall_err_cycles", n, LAT_TO);
    chk("stall_data", {30'b0, data_g, data_b}, 32'd3);
    chk("stall_busy", {30'b0, busy_g, busy_b}, 32'd0);
    repeat (5) @(posedge sys_clk);

    // Enable dropped at bit 5
    do_frame(PW'($urandom), 5);
    @(posedge sys_clk); #1 en = 1'b0; exp_err++;
    @(posedge sys_clk); @(negedge sys_clk);
    chk("endrop_data", {30'b0, data_g, data_b}, 32'd3);
    chk("endrop_busy", {30'b0, busy_g, busy_b}, 32'd0);
    chk("endrop_err", {30'b0, err_g, err_b}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      #1 ssi = 1'b0; repeat (H) @(posedge sys_clk);
      #1 ssi = 1'b1; repeat (H) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("dis_quiet", {28'b0, data_g, data_b, busy_g, busy_b}, 32'hC);
    end
    en = 1'b1;
    repeat (5) @(posedge sys_clk);

    // Fall 500 cycles into the monoflop is ignored and restarts it
    rp = PW'($urandom);
    do_frame(rp, PW + 1); exp_done++;
    repeat (500) @(posedge sys_clk);
    #1 ssi = 1'b0;
    repeat (H) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("mono_fall_data", {30'b0, data_g, data_b}, 32'd0);
    chk("mono_fall_busy", {30'b0, busy_g, busy_b}, 32'd3);
    @(posedge sys_clk); #1 ssi = 1'b1;
    repeat (3) @(posedge sys_clk); @(negedge sys_clk);
    chk("mono_rise_data", {30'b0, data_g, data_b}, 32'd0);
    wait_evt(0, n);
    chk("mono_restart_cycles", n, LAT_TO);

    // Enable dropped during the monoflop: no error
    do_frame(PW'($urandom), PW + 1); exp_done++;
    repeat (100) @(posedge sys_clk);
    #1 en = 1'b0;
    @(posedge sys_clk); @(negedge sys_clk);
    chk("mono_dis_err", {30'b0, err_g, err_b}, 32'd0);
    chk("mono_dis_data", {30'b0, data_g, data_b}, 32'd3);
    en = 1'b1;
    repeat (5) @(posedge sys_clk);

    // Reset mid-frame aborts silently
    do_frame(PW'($urandom), 4);
    @(posedge sys_clk); #3 reset_n = 1'b0;
    #1;
    chk("midrst_data", {30'b0, data_g, data_b}, 32'd3);
    chk("midrst_busy", {30'b0, busy_g, busy_b}, 32'd0);
    repeat (3) @(posedge sys_clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge sys_clk);
    do_frame(PW'($urandom), PW + 1); exp_done++;
    wait_evt(0, n);
    chk("post_rst_cycles", n, LAT_TO);

    // Random-position frames
    for (int f = 0; f < 2; f++) begin
      do_frame(PW'($urandom), PW + 1); exp_done++;
      wait_evt(0, n);
      chk("rand_release_cycles", n, LAT_TO);
    end

    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("done_count_g", dcnt_g, exp_done);
    chk("done_count_b", dcnt_b, exp_done);
    chk("err_count_g", ecnt_g, exp_err);
    chk("err_count_b", ecnt_b, exp_err);
    chk("done_err_overlap", both_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
